// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: renamed micro-op packet,
// station slot layout and default sizing.
package alu_rs_pkg;

    localparam int unsigned P_WIDTH      = 6;
    localparam int unsigned ROB_WIDTH    = 5;
    localparam int unsigned ALU_RS_DEPTH = 8;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef struct packed {
        alu_op_t                aluop;
        logic                   rs1_use;
        logic                   rs2_use;
        logic [P_WIDTH-1:0]     rs1_paddr;
        logic [P_WIDTH-1:0]     rs2_paddr;
        logic [P_WIDTH-1:0]     pd_paddr;
        logic [ROB_WIDTH-1:0]   rob_idx;
        logic [31:0]            imm;
    } RS_t;

    typedef struct packed {
        logic vld;
        logic r1;
        logic r2;
        RS_t  uop;
    } alu_rs_slot_t;

endpackage

// File: rtl/alu_rs_oldest_sel.sv
// Fixed-priority encoder: grants the lowest-index request, which in an
// age-ordered station is the oldest ready entry.
module rs_oldest_sel #(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0]         req,
    output logic                     gnt_valid,
    output logic [$clog2(DEPTH)-1:0] gnt_idx
);

    localparam int unsigned IW = $clog2(DEPTH);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (req[i] && !gnt_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: compacting age-ordered queue with CDB wakeup,
// same-cycle dispatch bypass and oldest-ready issue.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned DEPTH   = ALU_RS_DEPTH,
    parameter int unsigned N_CDB   = 2,
    parameter int unsigned P_WIDTH = alu_rs_pkg::P_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            dispatch_valid,
    input  RS_t                             dispatch_entry,
    input  logic                            dispatch_rs1_ready,
    input  logic                            dispatch_rs2_ready,
    output logic                            dispatch_ready,
    input  logic [N_CDB-1:0]                cdb_valid,
    input  logic [N_CDB-1:0][P_WIDTH-1:0]   cdb_paddr,
    output logic                            issue_valid,
    output RS_t                             issue_entry,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned IW = $clog2(DEPTH);

    alu_rs_slot_t   slot_q  [DEPTH];
    alu_rs_slot_t   woke    [DEPTH];
    alu_rs_slot_t   shifted [DEPTH];
    alu_rs_slot_t   slot_d  [DEPTH];
    alu_rs_slot_t   new_slot;
    logic [CW-1:0]  count_q;
    logic [DEPTH-1:0] req;
    logic [IW-1:0]  issue_idx;
    logic           accept;
    int unsigned    app_idx;

    // Select looks only at registered ready bits, keeping CDB off the issue path.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            req[i] = slot_q[i].vld & slot_q[i].r1 & slot_q[i].r2;
        end
    end

    rs_oldest_sel #(
        .DEPTH (DEPTH)
    ) u_sel (
        .req       (req),
        .gnt_valid (issue_valid),
        .gnt_idx   (issue_idx)
    );

    assign issue_entry    = issue_valid ? slot_q[issue_idx].uop : '0;
    assign count          = count_q;
    assign dispatch_ready = (count_q < CW'(DEPTH));
    assign accept         = dispatch_valid & dispatch_ready;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woke[i] = slot_q[i];
            for (int unsigned p = 0; p < N_CDB; p++) begin
                if (cdb_valid[p]) begin
                    if (cdb_paddr[p] == P_WIDTH'(slot_q[i].uop.rs1_paddr)) woke[i].r1 = 1'b1;
                    if (cdb_paddr[p] == P_WIDTH'(slot_q[i].uop.rs2_paddr)) woke[i].r2 = 1'b1;
                end
            end
        end

        new_slot     = '0;
        new_slot.vld = 1'b1;
        new_slot.uop = dispatch_entry;
        new_slot.r1  = !dispatch_entry.rs1_use || (dispatch_entry.rs1_paddr == '0) || dispatch_rs1_ready;
        new_slot.r2  = !dispatch_entry.rs2_use || (dispatch_entry.rs2_paddr == '0) || dispatch_rs2_ready;
        for (int unsigned p = 0; p < N_CDB; p++) begin
            if (cdb_valid[p]) begin
                if (cdb_paddr[p] == P_WIDTH'(dispatch_entry.rs1_paddr)) new_slot.r1 = 1'b1;
                if (cdb_paddr[p] == P_WIDTH'(dispatch_entry.rs2_paddr)) new_slot.r2 = 1'b1;
            end
        end
    end

    // Order of effects: wakeup, then removal of the issued slot, then append.
    always_comb begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            shifted[i] = woke[i+1];
        end
        shifted[DEPTH-1] = '0;

        app_idx = 32'(count_q) - 32'(issue_valid);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (issue_valid && (i >= 32'(issue_idx))) begin
                slot_d[i] = shifted[i];
            end else begin
                slot_d[i] = woke[i];
            end
            if (accept && (i == app_idx)) begin
                slot_d[i] = new_slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_q + CW'(accept) - CW'(issue_valid);
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the station.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned N_CDB = 2;
    localparam int unsigned PW    = alu_rs_pkg::P_WIDTH;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       dispatch_valid;
    RS_t                        dispatch_entry;
    logic                       dispatch_rs1_ready;
    logic                       dispatch_rs2_ready;
    logic                       dispatch_ready;
    logic [N_CDB-1:0]           cdb_valid;
    logic [N_CDB-1:0][PW-1:0]   cdb_paddr;
    logic                       issue_valid;
    RS_t                        issue_entry;
    logic [3:0]                 count;

    always #5 clk = ~clk;

    alu_rs #(
        .DEPTH   (DEPTH),
        .N_CDB   (N_CDB),
        .P_WIDTH (PW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_entry     (dispatch_entry),
        .dispatch_rs1_ready (dispatch_rs1_ready),
        .dispatch_rs2_ready (dispatch_rs2_ready),
        .dispatch_ready     (dispatch_ready),
        .cdb_valid          (cdb_valid),
        .cdb_paddr          (cdb_paddr),
        .issue_valid        (issue_valid),
        .issue_entry        (issue_entry),
        .count              (count)
    );

    typedef struct {
        RS_t uop;
        bit  r1;
        bit  r2;
    } ent_t;

    ent_t q[$];
    int   issued[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   checking = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit hit(input logic [PW-1:0] tag);
        for (int p = 0; p < N_CDB; p++) begin
            if (cdb_valid[p] && cdb_paddr[p] == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int oldest_ready();
        foreach (q[i]) begin
            if (q[i].r1 && q[i].r2) return i;
        end
        return -1;
    endfunction

    // Model of one clock edge, using the inputs currently applied.
    function automatic void model_step();
        int   sel;
        bit   acc;
        ent_t ne;
        if (rst || flush) begin
            q.delete();
            return;
        end
        sel    = oldest_ready();
        acc    = dispatch_valid && (q.size() < DEPTH);
        ne.uop = dispatch_entry;
        ne.r1  = !dispatch_entry.rs1_use || dispatch_entry.rs1_paddr == 0 || dispatch_rs1_ready || hit(dispatch_entry.rs1_paddr);
        ne.r2  = !dispatch_entry.rs2_use || dispatch_entry.rs2_paddr == 0 || dispatch_rs2_ready || hit(dispatch_entry.rs2_paddr);
        foreach (q[i]) begin
            if (hit(q[i].uop.rs1_paddr)) q[i].r1 = 1'b1;
            if (hit(q[i].uop.rs2_paddr)) q[i].r2 = 1'b1;
        end
        if (sel >= 0) q.delete(sel);
        if (acc) q.push_back(ne);
    endfunction

    always @(negedge clk) begin
        int  sel;
        RS_t exp_e;
        if (checking) begin
            sel   = oldest_ready();
            exp_e = '0;
            if (sel >= 0) exp_e = q[sel].uop;
            check("issue_valid", 64'(issue_valid), 64'(sel >= 0));
            check("issue_entry", 64'(issue_entry), 64'(exp_e));
            check("count", 64'(count), 64'(q.size()));
            check("dispatch_ready", 64'(dispatch_ready), 64'(q.size() < DEPTH));
        end
    end

    function automatic RS_t mk(input int rob, input bit u1, input int p1, input bit u2, input int p2);
        RS_t e;
        e.aluop     = ALU_ADD;
        e.rs1_use   = u1;
        e.rs1_paddr = PW'(p1);
        e.rs2_use   = u2;
        e.rs2_paddr = PW'(p2);
        e.pd_paddr  = PW'(rob + 1);
        e.rob_idx   = 5'(rob);
        e.imm       = 32'(rob * 3 + 1);
        return e;
    endfunction

    task automatic cyc(input bit dv, input RS_t e, input bit rr1, input bit rr2,
                       input bit [1:0] cv, input int c0, input int c1, input bit fl, input bit rs);
        dispatch_valid     = dv;
        dispatch_entry     = e;
        dispatch_rs1_ready = rr1;
        dispatch_rs2_ready = rr2;
        cdb_valid          = cv;
        cdb_paddr[0]       = PW'(c0);
        cdb_paddr[1]       = PW'(c1);
        flush              = fl;
        rst                = rs;
        if (issue_valid === 1'b1) issued.push_back(int'(issue_entry.rob_idx));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic disp(input RS_t e, input bit rr1, input bit rr2);
        cyc(1'b1, e, rr1, rr2, 2'b00, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wake(input int port, input int tag);
        if (port == 0) cyc(1'b0, '0, 1'b0, 1'b0, 2'b01, tag, 0, 1'b0, 1'b0);
        else           cyc(1'b0, '0, 1'b0, 1'b0, 2'b10, 0, tag, 1'b0, 1'b0);
    endtask

    initial begin
        RS_t e;
        int  exp_order[8];
        exp_order = '{10, 11, 13, 14, 16, 17, 15, 12};

        cyc(1'b0, '0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
        checking = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_entry", 64'(issue_entry), 64'd0);

        // ready dispatch issues the next cycle
        e = mk(1, 1'b1, 3, 1'b1, 4);
        disp(e, 1'b1, 1'b1);
        check("ready_count1", 64'(count), 64'd1);
        check("ready_issue_valid", 64'(issue_valid), 64'd1);
        check("ready_issue_entry", 64'(issue_entry), 64'(e));
        idle();
        check("ready_count0", 64'(count), 64'd0);

        // wakeup via CDB port 1
        disp(mk(2, 1'b1, 12, 1'b0, 0), 1'b0, 1'b1);
        repeat (3) begin
            idle();
            check("wake_blocked", 64'(issue_valid), 64'd0);
        end
        wake(1, 12);
        check("wake_issue_valid", 64'(issue_valid), 64'd1);
        check("wake_issue_rob", 64'(issue_entry.rob_idx), 64'd2);
        idle();

        // same-cycle bypass
        cyc(1'b1, mk(3, 1'b0, 0, 1'b1, 7), 1'b1, 1'b0, 2'b01, 7, 0, 1'b0, 1'b0);
        check("bypass_issue_valid", 64'(issue_valid), 64'd1);
        check("bypass_issue_rob", 64'(issue_entry.rob_idx), 64'd3);
        idle();

        // age order with a full queue
        issued.delete();
        for (int k = 0; k < 8; k++) begin
            disp(mk(10 + k, 1'b1, (k == 2) ? 42 : (k == 5) ? 45 : 40, 1'b0, 0), 1'b0, 1'b1);
        end
        check("full_count", 64'(count), 64'd8);
        check("full_ready", 64'(dispatch_ready), 64'd0);
        disp(mk(31, 1'b0, 0, 1'b0, 0), 1'b1, 1'b1);
        check("full_drop_count", 64'(count), 64'd8);
        wake(0, 40);
        check("first_issue_ready", 64'(dispatch_ready), 64'd0);
        check("first_issue_valid", 64'(issue_valid), 64'd1);
        idle();
        check("after_issue_ready", 64'(dispatch_ready), 64'd1);
        check("after_issue_count", 64'(count), 64'd7);
        repeat (5) idle();
        wake(0, 45);
        wake(1, 42);
        repeat (2) idle();
        check("age_issue_count", 64'(issued.size()), 64'd8);
        for (int k = 0; k < 8 && k < issued.size(); k++) begin
            check("age_order", 64'(issued[k]), 64'(exp_order[k]));
        end

        // dispatch, issue of slot 1 and wakeup of slot 2 in one cycle
        disp(mk(20, 1'b1, 50, 1'b0, 0), 1'b0, 1'b1);
        disp(mk(21, 1'b1, 51, 1'b0, 0), 1'b0, 1'b1);
        disp(mk(22, 1'b1, 52, 1'b0, 0), 1'b0, 1'b1);
        wake(0, 51);
        check("simul_pre_rob", 64'(issue_entry.rob_idx), 64'd21);
        cyc(1'b1, mk(23, 1'b0, 0, 1'b0, 0), 1'b1, 1'b1, 2'b01, 52, 0, 1'b0, 1'b0);
        check("simul_count", 64'(count), 64'd3);
        check("simul_next_rob", 64'(issue_entry.rob_idx), 64'd22);
        idle();
        check("simul_then_rob", 64'(issue_entry.rob_idx), 64'd23);
        idle();
        wake(0, 50);
        repeat (2) idle();

        // flush and reset mid-operation drop everything
        for (int k = 0; k < 5; k++) disp(mk(40 + k, 1'b1, 60, 1'b0, 0), 1'b0, 1'b1);
        check("preflush_count", 64'(count), 64'd5);
        cyc(1'b1, mk(46, 1'b0, 0, 1'b0, 0), 1'b1, 1'b1, 2'b00, 0, 0, 1'b1, 1'b0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_issue_valid", 64'(issue_valid), 64'd0);
        for (int k = 0; k < 3; k++) disp(mk(50 + k, 1'b1, 61, 1'b0, 0), 1'b0, 1'b1);
        cyc(1'b1, mk(54, 1'b0, 0, 1'b0, 0), 1'b1, 1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_issue_valid", 64'(issue_valid), 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            e           = mk(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                             1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            e.aluop     = alu_op_t'($urandom_range(0, 9));
            e.imm       = $urandom;
            cyc($urandom_range(0, 3) != 0, e, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                2'($urandom_range(0, 3)), int'($urandom_range(1, 15)), int'($urandom_range(1, 15)),
                $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
        end
        repeat (4) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
